// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_NORMAL,
    RESP_FREEZE,
    RESP_FLUSH,
    RESP_LOADUSE
  } resp_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register control outputs of the controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] IFID_RS_i;
  logic [4:0] IFID_RT_i;
  logic       IFID_UseRT_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RT_i;
  logic       Branch_i;
  logic       MemBusy_i;
  logic       PCWrite_o;
  logic       IFID_Write_o;
  logic       IDEX_Write_o;
  logic       EXMEM_Write_o;
  logic       IFID_Flush_o;
  logic       IDEX_Flush_o;
  logic       EXMEM_Flush_o;
  logic       MEMWB_Bubble_o;

  modport master (
    output IFID_RS_i, IFID_RT_i, IFID_UseRT_i, IDEX_MemRead_i, IDEX_RT_i,
           Branch_i, MemBusy_i,
    input  PCWrite_o, IFID_Write_o, IDEX_Write_o, EXMEM_Write_o,
           IFID_Flush_o, IDEX_Flush_o, EXMEM_Flush_o, MEMWB_Bubble_o
  );

  modport slave (
    input  IFID_RS_i, IFID_RT_i, IFID_UseRT_i, IDEX_MemRead_i, IDEX_RT_i,
           Branch_i, MemBusy_i,
    output PCWrite_o, IFID_Write_o, IDEX_Write_o, EXMEM_Write_o,
           IFID_Flush_o, IDEX_Flush_o, EXMEM_Flush_o, MEMWB_Bubble_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MEM-resolved branch flushes,
// data-memory wait states, plus saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  state_e state_q, state_d;
  logic   br_pend_q, br_pend_d;
  resp_e  resp;
  logic   lu_hz;
  logic   stall_inc, flush_inc;

  assign lu_hz = bus.IDEX_MemRead_i & (bus.IDEX_RT_i != REG_ZERO) &
                 ((bus.IDEX_RT_i == bus.IFID_RS_i) |
                  (bus.IFID_UseRT_i & (bus.IDEX_RT_i == bus.IFID_RT_i)));

  always_comb begin
    state_d   = state_q;
    br_pend_d = br_pend_q;
    resp      = RESP_NORMAL;
    unique case (state_q)
      RUN, LU_STALL: begin
        // The bubble already inserted resolves the hazard, so LU_STALL masks it.
        if (bus.MemBusy_i) begin
          resp      = RESP_FREEZE;
          br_pend_d = br_pend_q | bus.Branch_i;
          state_d   = MEM_WAIT;
        end else if (bus.Branch_i) begin
          resp    = RESP_FLUSH;
          state_d = RUN;
        end else if (lu_hz && (state_q == RUN)) begin
          resp    = RESP_LOADUSE;
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.MemBusy_i) begin
          resp      = RESP_FREEZE;
          br_pend_d = br_pend_q | bus.Branch_i;
        end else if (br_pend_q || bus.Branch_i) begin
          resp      = RESP_FLUSH;
          br_pend_d = 1'b0;
          state_d   = RUN;
        end else if (lu_hz) begin
          resp    = RESP_LOADUSE;
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        br_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
    end
  end

  always_comb begin
    bus.PCWrite_o      = 1'b1;
    bus.IFID_Write_o   = 1'b1;
    bus.IDEX_Write_o   = 1'b1;
    bus.EXMEM_Write_o  = 1'b1;
    bus.IFID_Flush_o   = 1'b0;
    bus.IDEX_Flush_o   = 1'b0;
    bus.EXMEM_Flush_o  = 1'b0;
    bus.MEMWB_Bubble_o = 1'b0;
    unique case (resp)
      RESP_FREEZE: begin
        bus.PCWrite_o      = 1'b0;
        bus.IFID_Write_o   = 1'b0;
        bus.IDEX_Write_o   = 1'b0;
        bus.EXMEM_Write_o  = 1'b0;
        bus.MEMWB_Bubble_o = 1'b1;
      end
      RESP_FLUSH: begin
        bus.IFID_Flush_o  = 1'b1;
        bus.IDEX_Flush_o  = 1'b1;
        bus.EXMEM_Flush_o = 1'b1;
      end
      RESP_LOADUSE: begin
        bus.PCWrite_o    = 1'b0;
        bus.IFID_Write_o = 1'b0;
        bus.IDEX_Flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_inc = ~bus.PCWrite_o;
  assign flush_inc = (resp == RESP_FLUSH);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (StallCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (FlushCnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural pipeline-response model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = 15;

  // {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Bubble}
  localparam logic [7:0] V_NORMAL  = 8'b1111_0000;
  localparam logic [7:0] V_FREEZE  = 8'b0000_0001;
  localparam logic [7:0] V_FLUSH   = 8'b1111_1110;
  localparam logic [7:0] V_LOADUSE = 8'b0011_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0] obs;

  int n_checks = 0;
  int n_bad = 0;

  // model state: what the pipeline still owes from earlier cycles
  bit m_bubble_done;
  bit m_mem_waiting;
  bit m_branch_owed;
  int m_stalls;
  int m_flushes;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .StallCnt_o (stall_cnt),
    .FlushCnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {bus.PCWrite_o, bus.IFID_Write_o, bus.IDEX_Write_o, bus.EXMEM_Write_o,
                bus.IFID_Flush_o, bus.IDEX_Flush_o, bus.EXMEM_Flush_o, bus.MEMWB_Bubble_o};

  task automatic idle_inputs();
    bus.IFID_RS_i      = 5'd1;
    bus.IFID_RT_i      = 5'd2;
    bus.IFID_UseRT_i   = 1'b0;
    bus.IDEX_MemRead_i = 1'b0;
    bus.IDEX_RT_i      = 5'd3;
    bus.Branch_i       = 1'b0;
    bus.MemBusy_i      = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    bus.IDEX_MemRead_i = 1'b1;
    bus.IDEX_RT_i      = rt;
    bus.IFID_RS_i      = rt;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_bubble_done = 0;
    m_mem_waiting = 0;
    m_branch_owed = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (obs !== V_NORMAL || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ctl=%b stall=%0d flush=%0d need ctl=%b stall=0 flush=0",
               obs, stall_cnt, flush_cnt, V_NORMAL);
    end
    apply_reset();
  endtask

  task automatic test_load_use();
    apply_reset();
    next_cycle();
    set_load_use(5'd8);
    @(negedge clk);
    n_checks++;
    if (obs !== V_LOADUSE) begin
      n_bad++;
      $display("FAIL lu_cycle0: ctl=%b need %b", obs, V_LOADUSE);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== V_NORMAL || stall_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL lu_cycle1: ctl=%b stall=%0d need ctl=%b stall=1", obs, stall_cnt, V_NORMAL);
    end
    // rt source case: same register through rt, only counts when rt is used
    apply_reset();
    next_cycle();
    bus.IDEX_MemRead_i = 1'b1;
    bus.IDEX_RT_i      = 5'd9;
    bus.IFID_RT_i      = 5'd9;
    bus.IFID_UseRT_i   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== V_LOADUSE) begin
      n_bad++;
      $display("FAIL lu_rt_used: ctl=%b need %b", obs, V_LOADUSE);
    end
  endtask

  task automatic test_no_stall_cases();
    apply_reset();
    next_cycle();
    bus.IDEX_MemRead_i = 1'b1;
    bus.IDEX_RT_i      = 5'd9;
    bus.IFID_RT_i      = 5'd9;
    bus.IFID_UseRT_i   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== V_NORMAL) begin
      n_bad++;
      $display("FAIL rt_unused: ctl=%b need %b", obs, V_NORMAL);
    end
    next_cycle();
    idle_inputs();
    set_load_use(5'd0);
    @(negedge clk);
    n_checks++;
    if (obs !== V_NORMAL) begin
      n_bad++;
      $display("FAIL reg_zero: ctl=%b need %b", obs, V_NORMAL);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL no_stall_cnt: stall=%0d need 0", stall_cnt);
    end
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    next_cycle();
    set_load_use(5'd8);
    bus.Branch_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== V_FLUSH) begin
      n_bad++;
      $display("FAIL br_hz_flush: ctl=%b need %b", obs, V_FLUSH);
    end
    next_cycle();
    bus.Branch_i = 1'b0;
    @(negedge clk);
    // still in RUN, so the held hazard must now stall
    n_checks++;
    if (obs !== V_LOADUSE || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL br_hz_after: ctl=%b flush=%0d stall=%0d need ctl=%b flush=1 stall=0",
               obs, flush_cnt, stall_cnt, V_LOADUSE);
    end
  endtask

  task automatic test_deferred_branch();
    apply_reset();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      bus.MemBusy_i = 1'b1;
      bus.Branch_i  = (i == 0);
      @(negedge clk);
      n_checks++;
      if (obs !== V_FREEZE) begin
        n_bad++;
        $display("FAIL defer_freeze%0d: ctl=%b need %b", i, obs, V_FREEZE);
      end
      next_cycle();
    end
    bus.MemBusy_i = 1'b0;
    bus.Branch_i  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== V_FLUSH || stall_cnt !== 4'd3) begin
      n_bad++;
      $display("FAIL defer_flush: ctl=%b stall=%0d need ctl=%b stall=3", obs, stall_cnt, V_FLUSH);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== V_NORMAL || flush_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL defer_once: ctl=%b flush=%0d need ctl=%b flush=1", obs, flush_cnt, V_NORMAL);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    next_cycle();
    bus.MemBusy_i = 1'b1;
    bus.Branch_i  = 1'b1;
    next_cycle();
    bus.Branch_i = 1'b0;
    #2;
    rst_n = 1'b0;
    bus.MemBusy_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_NORMAL || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_wait: ctl=%b stall=%0d flush=%0d need ctl=%b 0 0",
               obs, stall_cnt, flush_cnt, V_NORMAL);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== V_NORMAL || flush_cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_no_flush: ctl=%b flush=%0d need ctl=%b flush=0", obs, flush_cnt, V_NORMAL);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    next_cycle();
    set_load_use(5'd8);
    for (int i = 0; i < 40; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL stall_sat: stall=%0d need 15", stall_cnt);
    end
  endtask

  function automatic bit model_hazard();
    return bus.IDEX_MemRead_i && (bus.IDEX_RT_i != 0) &&
           ((bus.IDEX_RT_i == bus.IFID_RS_i) ||
            (bus.IFID_UseRT_i && (bus.IDEX_RT_i == bus.IFID_RT_i)));
  endfunction

  task automatic test_random();
    logic [7:0] exp_v;
    apply_reset();
    next_cycle();
    for (int c = 0; c < 500; c++) begin
      bus.IFID_RS_i      = 5'($urandom_range(0, 3));
      bus.IFID_RT_i      = 5'($urandom_range(0, 3));
      bus.IFID_UseRT_i   = 1'($urandom_range(0, 1));
      bus.IDEX_MemRead_i = 1'($urandom_range(0, 1));
      bus.IDEX_RT_i      = 5'($urandom_range(0, 3));
      bus.Branch_i       = ($urandom_range(0, 4) == 0);
      bus.MemBusy_i      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== CW'(m_stalls) || flush_cnt !== CW'(m_flushes)) begin
        n_bad++;
        $display("FAIL rand_cnt@%0d: stall=%0d flush=%0d need stall=%0d flush=%0d",
                 c, stall_cnt, flush_cnt, m_stalls, m_flushes);
      end
      if (bus.MemBusy_i) begin
        exp_v = V_FREEZE;
        m_branch_owed = m_branch_owed | bus.Branch_i;
        m_mem_waiting = 1;
        m_bubble_done = 0;
      end else if (bus.Branch_i || (m_mem_waiting && m_branch_owed)) begin
        exp_v = V_FLUSH;
        m_branch_owed = 0;
        m_mem_waiting = 0;
        m_bubble_done = 0;
      end else if (model_hazard() && !m_bubble_done) begin
        exp_v = V_LOADUSE;
        m_bubble_done = 1;
        m_mem_waiting = 0;
      end else begin
        exp_v = V_NORMAL;
        m_bubble_done = 0;
        m_mem_waiting = 0;
      end
      if (exp_v[7] == 1'b0 && m_stalls < CMAX) m_stalls++;
      if (exp_v == V_FLUSH && m_flushes < CMAX) m_flushes++;
      n_checks++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rand_ctl@%0d: ctl=%b need %b", c, obs, exp_v);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_branch_hazard();
    test_deferred_branch();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
